// File: rtl/lsu_subword_pkg.sv
// Shared definitions for the sub-word load/store unit: RV32I funct3
// width/sign codes and the control FSM state encoding.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WRITE  = 2'd2,
      RESP   = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_subword_if.sv
// Core request/response and data_mem signals of the load/store unit.
// 'slave' is the unit's view; 'master' is the view of the core plus memory.
interface lsu_subword_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault,
             mem_addr, mem_wdata, mem_write
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
             mem_addr, mem_wdata, mem_write
   );

endinterface

// File: rtl/lsu_subword_align.sv
// Combinational lane logic: extracts/extends load lanes, merges store
// lanes into the old memory word, and decodes illegal/misaligned requests.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] word_i,
   input  logic [31:0] old_i,
   input  logic [31:0] new_i,
   output logic [31:0] load_o,
   output logic [31:0] store_o,
   output logic        fault_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        illegal;
   logic        misaligned;

   // Load path: select the addressed lane and sign/zero extend it.
   always_comb begin
      byte_lane = 8'd0;
      case (offset_i)
         2'd0:    byte_lane = word_i[7:0];
         2'd1:    byte_lane = word_i[15:8];
         2'd2:    byte_lane = word_i[23:16];
         2'd3:    byte_lane = word_i[31:24];
         default: byte_lane = 8'd0;
      endcase
      if (offset_i[1]) begin
         half_lane = word_i[31:16];
      end else begin
         half_lane = word_i[15:0];
      end
      case (funct3_i)
         F3_B:    load_o = {{24{byte_lane[7]}}, byte_lane};
         F3_BU:   load_o = {24'd0, byte_lane};
         F3_H:    load_o = {{16{half_lane[15]}}, half_lane};
         F3_HU:   load_o = {16'd0, half_lane};
         F3_W:    load_o = word_i;
         default: load_o = 32'd0;
      endcase
   end

   // Store path: replace only the addressed lane of the old word.
   always_comb begin
      store_o = old_i;
      case (funct3_i)
         F3_B: begin
            case (offset_i)
               2'd0:    store_o = {old_i[31:8], new_i[7:0]};
               2'd1:    store_o = {old_i[31:16], new_i[7:0], old_i[7:0]};
               2'd2:    store_o = {old_i[31:24], new_i[7:0], old_i[15:0]};
               2'd3:    store_o = {new_i[7:0], old_i[23:0]};
               default: store_o = old_i;
            endcase
         end
         F3_H: begin
            if (offset_i[1]) begin
               store_o = {new_i[15:0], old_i[15:0]};
            end else begin
               store_o = {old_i[31:16], new_i[15:0]};
            end
         end
         F3_W:    store_o = new_i;
         default: store_o = old_i;
      endcase
   end

   // Fault decode: width code not legal for the direction, or lane misaligned.
   always_comb begin
      if (we_i) begin
         illegal = !(funct3_i == F3_B || funct3_i == F3_H || funct3_i == F3_W);
      end else begin
         illegal = !(funct3_i == F3_B  || funct3_i == F3_H || funct3_i == F3_W ||
                     funct3_i == F3_BU || funct3_i == F3_HU);
      end
      case (funct3_i)
         F3_H, F3_HU: misaligned = offset_i[0];
         F3_W:        misaligned = (offset_i != 2'd0);
         default:     misaligned = 1'b0;
      endcase
      fault_o = illegal | misaligned;
   end

endmodule

// File: rtl/lsu_subword.sv
// Load/store unit in front of a word-only data_mem. Sub-word stores are a
// read-modify-write; loads are lane-selected and extended per funct3.
module lsu_subword
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1024   // power of two; word index aliases modulo DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   lsu_subword_if.slave  bus
);

   localparam logic [31:0] IDX_MASK = 32'(DEPTH - 1);

   lsu_state_t        state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        offset_q, offset_d;
   logic [WIDTH-1:0]  wdata_q, wdata_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic              mem_write_q, mem_write_d;
   logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic              rsp_fault_q, rsp_fault_d;
   logic              req_ready_q, req_ready_d;

   logic              al_we;
   logic [2:0]        al_funct3;
   logic [1:0]        al_offset;
   logic [31:0]       al_load;
   logic [31:0]       al_store;
   logic              al_fault;
   logic              mem_write_s;

   // In IDLE the aligner decodes the incoming request for faults; in later
   // states it works on the latched request against the memory read data.
   always_comb begin
      if (state_q == IDLE) begin
         al_we     = bus.req_we;
         al_funct3 = bus.req_funct3;
         al_offset = bus.req_addr[1:0];
      end else begin
         al_we     = we_q;
         al_funct3 = funct3_q;
         al_offset = offset_q;
      end
   end

   lsu_align u_align (
      .we_i     (al_we),
      .funct3_i (al_funct3),
      .offset_i (al_offset),
      .word_i   (bus.mem_rdata),
      .old_i    (bus.mem_rdata),
      .new_i    (wdata_q),
      .load_o   (al_load),
      .store_o  (al_store),
      .fault_o  (al_fault)
   );

   // Next-state and next-output logic; all outputs are registered one step
   // ahead so they are valid in the state they belong to.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      offset_d    = offset_q;
      wdata_d     = wdata_q;
      mem_addr_d  = mem_addr_q;
      mem_write_d = 1'b0;
      mem_wdata_d = '0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_fault_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d     = bus.req_we;
               funct3_d = bus.req_funct3;
               offset_d = bus.req_addr[1:0];
               wdata_d  = bus.req_wdata;
               if (al_fault) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_fault_d = 1'b1;
               end else begin
                  state_d    = ACCESS;
                  mem_addr_d = {2'b00, bus.req_addr[31:2]} & IDX_MASK;
                  // A full-word store needs no read, so it writes in ACCESS.
                  if (bus.req_we && bus.req_funct3 == F3_W) begin
                     mem_write_d = 1'b1;
                     mem_wdata_d = bus.req_wdata;
                  end else begin
                     mem_write_d = 1'b0;
                  end
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            if (!we_q) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = al_load;
            end else if (funct3_q == F3_W) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
            end else begin
               // Merge is computed from this cycle's read data and held for WRITE.
               state_d     = WRITE;
               mem_write_d = 1'b1;
               mem_wdata_d = al_store;
            end
         end
         WRITE: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      req_ready_d = (state_d == IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         offset_q    <= 2'b00;
         wdata_q     <= '0;
         mem_addr_q  <= 32'd0;
         mem_write_q <= 1'b0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_fault_q <= 1'b0;
         req_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         offset_q    <= offset_d;
         wdata_q     <= wdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_write_q <= mem_write_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_fault_q <= rsp_fault_d;
         req_ready_q <= req_ready_d;
      end
   end

   // Reset must suppress a write already scheduled for the current cycle,
   // so the write strobe is gated combinationally rather than waiting an edge.
   assign mem_write_s   = mem_write_q & ~reset;
   assign bus.mem_write = mem_write_s;
   assign bus.mem_wdata = mem_write_s ? mem_wdata_q : 32'd0;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_fault = rsp_fault_q;

endmodule
